// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: recovers USB bit timing from the synchronized D+/D- pair,
// decodes NRZI, drops stuffed bits and detects end of packet (SE0 then J).
// Emits one-cycle bit strobes for the RX shift register / packet FSM.
// Optional build macro USB_RX_STUFF_ERR_EN adds the stuff_err_RX output and
// aborts reception on a bit-stuffing violation.
module usb_rx_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic dp_in,
   input  logic dm_in,
   input  logic rx_enable,
   output logic bit_valid_RX,
   output logic bit_data_RX,
   output logic eop_RX,
   output logic rx_active
`ifdef USB_RX_STUFF_ERR_EN
   ,
   output logic stuff_err_RX
`endif
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] HALF_C = CW'(HALF);
   localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   // Line states as {dp, dm}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;
   localparam logic [1:0] LINE_SE1 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_EOP_WAIT = 2'd2
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    ones_reg;
   logic [1:0]    se0_cnt_reg;
   logic [1:0]    prev_line_reg;
   logic [1:0]    last_sample_reg;

   logic [1:0] line;
   logic [1:0] eff_line;
   logic       cur_jk;
   logic       prev_jk;
   logic       edge_det;
   logic       sample;
   logic       bit_val;

   // Line decode, J<->K edge detection and sample-point selection
   always_comb begin
      line     = {dp_in, dm_in};
      // SE1 is meaningless on the bus: behave as if the line did not change
      eff_line = (line == LINE_SE1) ? prev_line_reg : line;
      cur_jk   = (eff_line == LINE_J) || (eff_line == LINE_K);
      prev_jk  = (prev_line_reg == LINE_J) || (prev_line_reg == LINE_K);
      // Only genuine J<->K transitions resync; entering/leaving SE0 does not
      edge_det = cur_jk && prev_jk && (eff_line != prev_line_reg);
      // An edge landing on the sample point wins: resync instead of sampling
      sample   = (cnt_reg == HALF_C) && !edge_det;
      bit_val  = (eff_line == last_sample_reg);
   end

   // Receive FSM: bit counter, NRZI decode, unstuffing, EOP detection
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         ones_reg        <= '0;
         se0_cnt_reg     <= '0;
         prev_line_reg   <= LINE_J;
         last_sample_reg <= LINE_J;
         bit_valid_RX    <= 1'b0;
         bit_data_RX     <= 1'b0;
         eop_RX          <= 1'b0;
         rx_active       <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
         stuff_err_RX    <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle by default
         bit_valid_RX  <= 1'b0;
         eop_RX        <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
         stuff_err_RX  <= 1'b0;
`endif
         prev_line_reg <= eff_line;

         case (state_reg)
            ST_IDLE: begin
               // SYNC starts with the first J->K transition
               if (rx_enable && edge_det && (eff_line == LINE_K)) begin
                  state_reg       <= ST_ACTIVE;
                  cnt_reg         <= ONE_C;
                  last_sample_reg <= LINE_J;
                  ones_reg        <= '0;
                  se0_cnt_reg     <= '0;
                  rx_active       <= 1'b1;
               end
            end

            ST_ACTIVE: begin
               if (!rx_enable) begin
                  state_reg <= ST_IDLE;
                  rx_active <= 1'b0;
               end else begin
                  if (edge_det)
                     cnt_reg <= ONE_C;
                  else if (cnt_reg == LAST_C)
                     cnt_reg <= '0;
                  else
                     cnt_reg <= cnt_reg + ONE_C;

                  if (sample) begin
                     if (eff_line == LINE_SE0) begin
                        // Second consecutive SE0 bit time marks EOP
                        se0_cnt_reg <= se0_cnt_reg + 2'd1;
                        if (se0_cnt_reg == 2'd1)
                           state_reg <= ST_EOP_WAIT;
                     end else begin
                        last_sample_reg <= eff_line;
                        se0_cnt_reg     <= '0;
                        if (ones_reg == 3'd6) begin
                           // Bit after six 1s is a stuffed bit: never forwarded
                           ones_reg <= '0;
`ifdef USB_RX_STUFF_ERR_EN
                           if (bit_val) begin
                              stuff_err_RX <= 1'b1;
                              rx_active    <= 1'b0;
                              state_reg    <= ST_IDLE;
                           end
`endif
                        end else begin
                           bit_valid_RX <= 1'b1;
                           bit_data_RX  <= bit_val;
                           ones_reg     <= bit_val ? (ones_reg + 3'd1) : 3'd0;
                        end
                     end
                  end
               end
            end

            ST_EOP_WAIT: begin
               if (!rx_enable) begin
                  state_reg <= ST_IDLE;
                  rx_active <= 1'b0;
               end else if (eff_line == LINE_J) begin
                  eop_RX    <= 1'b1;
                  rx_active <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (eff_line == LINE_K) begin
                  // K after SE0 is not a valid EOP: abandon without a pulse
                  rx_active <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               rx_active <= 1'b0;
            end
         endcase
      end
   end

endmodule
